// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with round-robin or fixed-select arbitration
// and a single registered output beat.
module stream_mux_rr #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam logic [SELW-1:0] LastChan = SELW'(N - 1);

    logic [WIDTH-1:0] data_q, data_d;
    logic [SELW-1:0]  chan_q, chan_d;
    logic             valid_q, valid_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             load_en;
    logic [N-1:0]     grant;
    logic             grant_any;
    logic [SELW-1:0]  grant_idx;
    logic [WIDTH-1:0] grant_data;

    assign load_en = !valid_q || out_ready;

    // Round-robin: first pass covers ptr..N-1, second pass wraps to 0..ptr-1.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        if (mode) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (sel == SELW'(i) && in_valid[i]) begin
                    grant[i]  = 1'b1;
                    grant_any = 1'b1;
                    grant_idx = SELW'(i);
                end
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!grant_any && SELW'(i) >= ptr_q && in_valid[i]) begin
                    grant[i]  = 1'b1;
                    grant_any = 1'b1;
                    grant_idx = SELW'(i);
                end
            end
            for (int unsigned i = 0; i < N; i++) begin
                if (!grant_any && in_valid[i]) begin
                    grant[i]  = 1'b1;
                    grant_any = 1'b1;
                    grant_idx = SELW'(i);
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = load_en ? grant : '0;

    always_comb begin
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (load_en) begin
            if (grant_any) begin
                data_d  = grant_data;
                chan_d  = grant_idx;
                valid_d = 1'b1;
                if (!mode) begin
                    ptr_d = (grant_idx == LastChan) ? '0 : grant_idx + 1'b1;
                end
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_chan  = chan_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 4-channel instance plus a 5-channel instance for the
// non-power-of-two select and wrap cases.
module tb_stream_mux_rr;

    logic        clk;
    logic        rst;

    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;

    logic [39:0] in_data5;
    logic [4:0]  in_valid5;
    logic [4:0]  in_ready5;
    logic        mode5;
    logic [2:0]  sel5;
    logic [7:0]  out_data5;
    logic [2:0]  out_chan5;
    logic        out_valid5;
    logic        out_ready5;

    int checks = 0;
    int errors = 0;

    stream_mux_rr #(.WIDTH(8), .N(4), .SELW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    stream_mux_rr #(.WIDTH(8), .N(5), .SELW(3)) dut5 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data5),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .mode      (mode5),
        .sel       (sel5),
        .out_data  (out_data5),
        .out_chan  (out_chan5),
        .out_valid (out_valid5),
        .out_ready (out_ready5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; registered outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        in_data    = 32'hA3A2_A1A0;
        in_valid   = 4'hF;
        mode       = 1'b0;
        sel        = 2'd0;
        out_ready  = 1'b1;
        in_data5   = 40'hC4_C3C2_C1C0;
        in_valid5  = 5'h00;
        mode5      = 1'b0;
        sel5       = 3'd0;
        out_ready5 = 1'b1;

        // Reset held for two edges with every channel valid.
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_out_chan", 32'(out_chan), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        rst = 1'b0;

        // Round-robin with all channels valid: 0,1,2,3,0,1 back to back.
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rr_valid", 32'(out_valid), 32'd1);
            check("rr_chan", 32'(out_chan), 32'(k % 4));
            check("rr_data", 32'(out_data), 32'hA0 + 32'(k % 4));
            check("rr_in_ready", 32'(in_ready), 32'(1 << ((k + 1) % 4)));
        end
        tick();
        check("rr_chan_2", 32'(out_chan), 32'd2);
        check("rr_ptr_3", 32'(dut.ptr_q), 32'd3);

        // Skip and wrap from ptr = 3 with only channel 1 requesting.
        in_valid = 4'b0010;
        settle();
        check("skip_in_ready", 32'(in_ready), 32'b0010);
        tick();
        check("skip_chan", 32'(out_chan), 32'd1);
        check("skip_data", 32'(out_data), 32'hA1);
        check("skip_ptr", 32'(dut.ptr_q), 32'd2);
        in_valid = 4'b1001;
        settle();
        check("wrap_in_ready_3", 32'(in_ready), 32'b1000);
        tick();
        check("wrap_chan_3", 32'(out_chan), 32'd3);
        settle();
        check("wrap_in_ready_0", 32'(in_ready), 32'b0001);
        tick();
        check("wrap_chan_0", 32'(out_chan), 32'd0);
        check("wrap_ptr_1", 32'(dut.ptr_q), 32'd1);

        // Fixed select on channel 2; pointer must stay at 1.
        mode     = 1'b1;
        sel      = 2'd2;
        in_valid = 4'hF;
        settle();
        check("fix_in_ready", 32'(in_ready), 32'b0100);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("fix_chan", 32'(out_chan), 32'd2);
            check("fix_data", 32'(out_data), 32'hA2);
            check("fix_in_ready_run", 32'(in_ready), 32'b0100);
        end
        check("fix_ptr", 32'(dut.ptr_q), 32'd1);

        // Backpressure: output frozen and in_ready low for three cycles.
        out_ready = 1'b0;
        mode      = 1'b0;
        settle();
        check("bp_in_ready_now", 32'(in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'(out_data), 32'hA2);
            check("bp_chan", 32'(out_chan), 32'd2);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        settle();
        check("bp_release_in_ready", 32'(in_ready), 32'b0010);
        tick();
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_chan", 32'(out_chan), 32'd1);
        check("bp_next_data", 32'(out_data), 32'hA1);

        // Mid-stream reset while a beat is held under backpressure.
        out_ready = 1'b0;
        tick();
        check("mr_hold_chan", 32'(out_chan), 32'd1);
        rst = 1'b1;
        tick();
        check("mr_valid", 32'(out_valid), 32'd0);
        check("mr_data", 32'(out_data), 32'h00);
        check("mr_ptr", 32'(dut.ptr_q), 32'd0);
        rst       = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        tick();
        check("mr_no_ghost", 32'(out_valid), 32'd0);
        in_valid = 4'b0100;
        tick();
        check("mr_after_chan", 32'(out_chan), 32'd2);
        check("mr_after_valid", 32'(out_valid), 32'd1);

        // Five-channel instance: out-of-range select and non-power-of-two wrap.
        mode5     = 1'b1;
        sel5      = 3'd4;
        in_valid5 = 5'h1F;
        tick();
        check("n5_fix_chan", 32'(out_chan5), 32'd4);
        check("n5_fix_data", 32'(out_data5), 32'hC4);
        sel5 = 3'd5;
        settle();
        check("n5_bad_sel_in_ready", 32'(in_ready5), 32'd0);
        tick();
        check("n5_drain_valid", 32'(out_valid5), 32'd0);
        tick();
        check("n5_idle_valid", 32'(out_valid5), 32'd0);
        check("n5_hold_data", 32'(out_data5), 32'hC4);
        check("n5_hold_chan", 32'(out_chan5), 32'd4);
        mode5     = 1'b0;
        in_valid5 = 5'b10000;
        tick();
        check("n5_rr_chan4", 32'(out_chan5), 32'd4);
        check("n5_wrap_ptr", 32'(dut5.ptr_q), 32'd0);
        in_valid5 = 5'h1F;
        tick();
        check("n5_rr_chan0", 32'(out_chan5), 32'd0);
        check("n5_rr_data0", 32'(out_data5), 32'hC0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, WIDTH-bit multiplexer with per-channel valid/ready handshakes and a registered output stage. It is the sequential successor of the team's fixed 4:1 bit mux. It selects one input channel per cycle, either round-robin among requesting channels or under a fixed select. It sits between several producer streams and a single consumer and provides one beat of output buffering.

## Interface
- WIDTH, 8: data bits per channel
- N, 4: number of input channels (2..16, need not be a power of two)
- SELW, 2: select/channel-index width; must be ≥ ceil(log2(N))
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  N  per-channel beat present
- in_ready  out  N  per-channel beat accepted this cycle
- mode  in  1  0 = round-robin, 1 = fixed select
- sel  in  SELW  channel used when mode = 1
- out_data  out  WIDTH  registered output beat
- out_chan  out  SELW  source channel index of out_data
- out_valid  out  1  output beat present
- out_ready  in  1  consumer accepts out_data

## Operation
- One output register (out_data, out_chan, out_valid) forms a single-entry buffer.
- load_en = !out_valid | out_ready: the register may be overwritten this cycle.
- Grant, combinational, at most one bit set:
  - mode = 1: grant channel sel iff sel < N and in_valid[sel]. sel ≥ N means no grant.
  - mode = 0: grant the first channel i with in_valid[i], searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
- in_ready[i] = load_en & grant[i]. All other in_ready bits are 0. A transfer on channel i is in_valid[i] & in_ready[i].
- On load_en with a grant g: out_data <= channel g data, out_chan <= g, out_valid <= 1.
- On load_en with no grant: out_valid <= 0. out_data and out_chan hold their previous values.
- When !load_en (out_valid & !out_ready): the output register holds and all in_ready = 0.
- Round-robin pointer ptr (SELW bits, reset 0) updates only on an accepted grant in mode 0:
  - ptr <= g+1, wrapping N-1 → 0 (also for non-power-of-two N).
  - ptr is unchanged in mode 1 and on cycles with no transfer.
- mode and sel are sampled combinationally each cycle. Switching mode never drops or duplicates a beat.
- in_data is not required to be stable once in_valid is low. Producers must hold in_valid/in_data until their in_ready.

## Timing
- Reset (rst high at a clock edge):
  - out_valid = 0, out_data = 0, out_chan = 0, ptr = 0.
  - in_ready follows the rule above; with out_valid = 0 after reset it is driven by the grant only.
- Reset mid-operation: a held beat is discarded without handshake.
- Latency: an input transfer in cycle t appears on out_data/out_valid in cycle t+1.
- Throughput: one beat per cycle when out_ready is held high. No bubble between back-to-back beats.
- Backpressure: out_ready low with out_valid high freezes all outputs, and in_ready goes low in the same cycle (combinational path out_ready → in_ready).
- Simultaneous out-handshake and new grant: the old beat leaves and the new beat loads on the same edge.
- No combinational path from in_data to any output.

## Test plan
- Reset: hold rst 2 cycles with all in_valid = 1.
  - During reset: out_valid = 0, out_data = 0, out_chan = 0.
  - First cycle after reset: round-robin grants channel 0.
- Round-robin fairness: N = 4, mode = 0, all in_valid = 1, out_ready = 1, in_data[i] = 0xA0+i.
  - out_chan sequence is 0,1,2,3,0,1… on consecutive cycles.
  - out_data tracks the source channel (0xA0+out_chan).
- Skip and wrap: ptr = 3, only in_valid[1] = 1.
  - Channel 1 is granted and ptr becomes 2.
  - Then assert in_valid[0] and in_valid[3]: next grant is 3, then 0.
- Fixed mode: mode = 1, sel = 2, all valid.
  - Only channel 2 is ever accepted and ptr is unchanged.
  - sel = 5 with N = 5: no grant, and out_valid drops after the current beat drains.
- Backpressure: out_ready = 0 for 3 cycles while out_valid = 1.
  - out_data is stable and in_ready = 0 throughout.
  - Raise out_ready: the held beat is consumed and a new beat loads on the same edge, with no bubble and no loss.
- Mid-stream reset: assert rst while out_valid = 1 and out_ready = 0.
  - Next cycle: out_valid = 0 and ptr = 0.
  - The held beat never appears on the output.
